// File: rtl/trd_pc_sched_if.sv
// Bundle of the PC-selector / fetch side signals of the thread scheduler.
//
// Handshake: cur_vld qualifies cur_trd/cur_pc in the same cycle. There is no
// ready; the consumer holds the scheduler with stall, during which the issued
// thread/PC are frozen (cur_vld may only fall, never rise, while stalled).
interface trd_pc_sched_if;
    logic [31:0] nxt_pc_0;
    logic [31:0] nxt_pc_1;
    logic [31:0] nxt_pc_2;
    logic [31:0] nxt_pc_3;
    logic [31:0] nxt_pc_4;
    logic [31:0] nxt_pc_5;
    logic [31:0] nxt_pc_6;
    logic [31:0] nxt_pc_7;
    logic [7:0]  pc_wr;
    logic        stall;
    logic [7:0]  trd_en;
    logic        i_miss;
    logic [2:0]  i_miss_trd;
    logic        d_miss;
    logic [2:0]  d_miss_trd;
    logic        i_fill;
    logic [2:0]  i_fill_trd;
    logic        d_fill;
    logic [2:0]  d_fill_trd;
    logic [2:0]  cur_trd;
    logic [31:0] cur_pc;
    logic        cur_vld;
    logic [7:0]  trd_wait;

    // PC selector / pipeline side: drives next PCs, control and miss/fill events
    modport master (
        output nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3,
        output nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7,
        output pc_wr, stall, trd_en,
        output i_miss, i_miss_trd, d_miss, d_miss_trd,
        output i_fill, i_fill_trd, d_fill, d_fill_trd,
        input  cur_trd, cur_pc, cur_vld, trd_wait
    );

    // Scheduler side
    modport slave (
        input  nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3,
        input  nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7,
        input  pc_wr, stall, trd_en,
        input  i_miss, i_miss_trd, d_miss, d_miss_trd,
        input  i_fill, i_fill_trd, d_fill, d_fill_trd,
        output cur_trd, cur_pc, cur_vld, trd_wait
    );
endinterface

// File: rtl/trd_pc_sched.sv
// Per-thread PC register file and round-robin scheduler for the 8-thread
// barrel core. Threads with an outstanding I- or D-miss are parked until
// their fill returns.
//
// Build option: TRD_SCHED_BACK2BACK_EN
//   defined   - the last issued thread stays eligible (a lone thread issues
//               every cycle).
//   undefined - the last issued thread is skipped at the next non-stalled
//               edge (barrel interleave; a lone thread issues every other cycle).
module trd_pc_sched #(
    parameter logic [31:0] START_PC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    trd_pc_sched_if.slave  bus
);

`ifdef TRD_SCHED_BACK2BACK_EN
    localparam bit BACK2BACK = 1'b1;
`else
    localparam bit BACK2BACK = 1'b0;
`endif

    logic [31:0] nxt_pc [8];
    logic [31:0] pc_q   [8];

    logic [7:0]  iw_q;
    logic [7:0]  dw_q;
    logic [7:0]  iw_n;
    logic [7:0]  dw_n;
    logic [7:0]  elig;

    logic [2:0]  ptr_q;
    logic [2:0]  cur_trd_q;
    logic [31:0] cur_pc_q;
    logic        cur_vld_q;

    logic        found;
    logic [2:0]  sel;
    logic [31:0] sel_pc;
    logic        miss_on_cur;

    assign nxt_pc[0] = bus.nxt_pc_0;
    assign nxt_pc[1] = bus.nxt_pc_1;
    assign nxt_pc[2] = bus.nxt_pc_2;
    assign nxt_pc[3] = bus.nxt_pc_3;
    assign nxt_pc[4] = bus.nxt_pc_4;
    assign nxt_pc[5] = bus.nxt_pc_5;
    assign nxt_pc[6] = bus.nxt_pc_6;
    assign nxt_pc[7] = bus.nxt_pc_7;

    // Wait flags after this cycle's events; a miss overrides a same-cycle fill
    always_comb begin
        iw_n = iw_q;
        dw_n = dw_q;
        if (bus.i_fill) iw_n[bus.i_fill_trd] = 1'b0;
        if (bus.d_fill) dw_n[bus.d_fill_trd] = 1'b0;
        if (bus.i_miss) iw_n[bus.i_miss_trd] = 1'b1;
        if (bus.d_miss) dw_n[bus.d_miss_trd] = 1'b1;
    end

    // Runnable threads; in interleave mode the thread just issued sits out one edge
    always_comb begin
        elig = bus.trd_en & ~iw_n & ~dw_n;
        if (!BACK2BACK && cur_vld_q) elig[cur_trd_q] = 1'b0;
    end

    // Round-robin search starting after the last issued thread; offset 8 is ptr itself
    always_comb begin
        logic [2:0] cand;
        found = 1'b0;
        sel   = ptr_q;
        cand  = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr_q + 3'(k);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Forward a same-edge PC write so the issued PC is never stale
    always_comb begin
        sel_pc = bus.pc_wr[sel] ? nxt_pc[sel] : pc_q[sel];
    end

    // A miss on the currently presented thread invalidates it while stalled
    always_comb begin
        miss_on_cur = cur_vld_q &&
                      ((bus.i_miss && (bus.i_miss_trd == cur_trd_q)) ||
                       (bus.d_miss && (bus.d_miss_trd == cur_trd_q)));
    end

    // PC file: writes land regardless of stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int t = 0; t < 8; t++) pc_q[t] <= START_PC;
        end else begin
            for (int t = 0; t < 8; t++) begin
                if (bus.pc_wr[t]) pc_q[t] <= nxt_pc[t];
            end
        end
    end

    // Wait flags keep tracking misses/fills during stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iw_q <= 8'h00;
            dw_q <= 8'h00;
        end else begin
            iw_q <= iw_n;
            dw_q <= dw_n;
        end
    end

    // Issue register and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= 3'd7;
            cur_trd_q <= 3'd0;
            cur_pc_q  <= START_PC;
            cur_vld_q <= 1'b0;
        end else if (bus.stall) begin
            if (miss_on_cur) cur_vld_q <= 1'b0;
        end else if (found) begin
            ptr_q     <= sel;
            cur_trd_q <= sel;
            cur_pc_q  <= sel_pc;
            cur_vld_q <= 1'b1;
        end else begin
            cur_vld_q <= 1'b0;
        end
    end

    assign bus.cur_trd  = cur_trd_q;
    assign bus.cur_pc   = cur_pc_q;
    assign bus.cur_vld  = cur_vld_q;
    assign bus.trd_wait = iw_q | dw_q;

endmodule

// File: tb/tb_trd_pc_sched.sv
// Self-checking bench for trd_pc_sched: round-robin order, PC write
// forwarding, miss parking, stall behaviour, lone-thread cadence and
// asynchronous reset.
module tb_trd_pc_sched;

    localparam logic [31:0] START_PC = 32'h0000_0100;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // Expected {cur_vld, cur_trd, cur_pc} and trd_wait per observed cycle
    logic [35:0] exp_q  [$];
    logic [7:0]  wait_q [$];

    trd_pc_sched_if bus ();

    trd_pc_sched #(.START_PC(START_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        bus.nxt_pc_0 = 32'h0; bus.nxt_pc_1 = 32'h0;
        bus.nxt_pc_2 = 32'h0; bus.nxt_pc_3 = 32'h0;
        bus.nxt_pc_4 = 32'h0; bus.nxt_pc_5 = 32'h0;
        bus.nxt_pc_6 = 32'h0; bus.nxt_pc_7 = 32'h0;
        bus.pc_wr  = 8'h00;
        bus.stall  = 1'b0;
        bus.i_miss = 1'b0; bus.i_miss_trd = 3'd0;
        bus.d_miss = 1'b0; bus.d_miss_trd = 3'd0;
        bus.i_fill = 1'b0; bus.i_fill_trd = 3'd0;
        bus.d_fill = 1'b0; bus.d_fill_trd = 3'd0;
    endtask

    // Reset with all threads disabled; releases 1 time unit after an edge
    task automatic apply_reset();
        set_idle();
        bus.trd_en = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] got, exp;
        logic [7:0]  wexp;
        set_idle();
        bus.trd_en = 8'hFF;
        rst = 1'b1;
        #3;
        exp_q.push_back({1'b0, 3'd0, START_PC});
        wait_q.push_back(8'h00);
        @(posedge clk);
        #1;
        got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_out: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h",
                     got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
        end
        wexp = wait_q.pop_front();
        n_checks++;
        if (bus.trd_wait !== wexp) begin
            n_fail++;
            $display("FAIL reset_wait: got %h want %h", bus.trd_wait, wexp);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [35:0] got, exp;
        logic [7:0]  wexp;
        apply_reset();
        bus.trd_en = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({1'b1, 3'(i % 8), START_PC});
            wait_q.push_back(8'h00);
            @(posedge clk);
            #1;
            got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL rr[%0d]: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h", i,
                         got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
            end
            wexp = wait_q.pop_front();
            n_checks++;
            if (bus.trd_wait !== wexp) begin
                n_fail++;
                $display("FAIL rr_wait[%0d]: got %h want %h", i, bus.trd_wait, wexp);
            end
        end
    endtask

    task automatic test_forwarding();
        logic [35:0] got, exp;
        int          trd_tab [4] = '{2, 5, 2, 5};
        logic [31:0] pc_tab  [4] = '{32'h10, 32'h20, 32'h10, 32'h20};
        apply_reset();
        bus.trd_en   = 8'h24;
        bus.pc_wr    = 8'h24;
        bus.nxt_pc_2 = 32'h10;
        bus.nxt_pc_5 = 32'h20;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                bus.pc_wr    = 8'h00;
                bus.nxt_pc_2 = 32'hDEAD_0002;
                bus.nxt_pc_5 = 32'hDEAD_0005;
            end
            exp_q.push_back({1'b1, 3'(trd_tab[i]), pc_tab[i]});
            @(posedge clk);
            #1;
            got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL fwd[%0d]: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h", i,
                         got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_d_miss();
        logic [35:0] got, exp;
        logic [7:0]  wexp;
        int          trd_tab [10] = '{0, 1, 2, 3, 0, 2, 3, 0, 1, 2};
        apply_reset();
        bus.trd_en = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            bus.d_miss = (i == 2); bus.d_miss_trd = 3'd1;
            bus.d_fill = (i == 8); bus.d_fill_trd = 3'd1;
            exp_q.push_back({1'b1, 3'(trd_tab[i]), START_PC});
            wait_q.push_back((i >= 2 && i <= 7) ? 8'h02 : 8'h00);
            @(posedge clk);
            #1;
            got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL dmiss[%0d]: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h", i,
                         got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
            end
            wexp = wait_q.pop_front();
            n_checks++;
            if (bus.trd_wait !== wexp) begin
                n_fail++;
                $display("FAIL dmiss_wait[%0d]: got %h want %h", i, bus.trd_wait, wexp);
            end
        end
        set_idle();
    endtask

    task automatic test_miss_fill_same_cycle();
        logic [35:0] got, exp;
        logic [7:0]  wexp;
        int          trd_tab [12] = '{0, 1, 2, 3, 5, 6, 7, 0, 1, 2, 3, 4};
        apply_reset();
        bus.trd_en = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            bus.i_miss = (i == 0); bus.i_miss_trd = 3'd4;
            bus.i_fill = (i == 0) || (i == 6); bus.i_fill_trd = 3'd4;
            exp_q.push_back({1'b1, 3'(trd_tab[i]), START_PC});
            wait_q.push_back((i <= 5) ? 8'h10 : 8'h00);
            @(posedge clk);
            #1;
            got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL same_cyc[%0d]: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h", i,
                         got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
            end
            wexp = wait_q.pop_front();
            n_checks++;
            if (bus.trd_wait !== wexp) begin
                n_fail++;
                $display("FAIL same_cyc_wait[%0d]: got %h want %h", i, bus.trd_wait, wexp);
            end
        end
        set_idle();
    endtask

    task automatic test_stall();
        logic [35:0] got, exp;
        logic [7:0]  wexp;
        int          trd_tab [11] = '{0, 1, 1, 1, 1, 2, 3, 0, 1, 1, 2};
        logic        vld_tab [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [31:0] pc;
        apply_reset();
        bus.trd_en = 8'h0F;
        for (int i = 0; i < 11; i++) begin
            bus.stall    = (i >= 2 && i <= 4) || (i == 9);
            bus.pc_wr    = (i == 2) ? 8'h02 : 8'h00;
            bus.nxt_pc_1 = (i == 2) ? 32'h0000_0555 : 32'h0000_0999;
            bus.d_miss   = (i == 2); bus.d_miss_trd = 3'd1;
            bus.d_fill   = (i == 8); bus.d_fill_trd = 3'd1;
            pc = (i == 8 || i == 9) ? 32'h0000_0555 : START_PC;
            exp_q.push_back({vld_tab[i], 3'(trd_tab[i]), pc});
            wait_q.push_back((i >= 2 && i <= 7) ? 8'h02 : 8'h00);
            @(posedge clk);
            #1;
            got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stall[%0d]: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h", i,
                         got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
            end
            wexp = wait_q.pop_front();
            n_checks++;
            if (bus.trd_wait !== wexp) begin
                n_fail++;
                $display("FAIL stall_wait[%0d]: got %h want %h", i, bus.trd_wait, wexp);
            end
        end
        set_idle();
    endtask

    task automatic test_lone_thread_async_reset();
        logic [35:0] got, exp;
        logic [7:0]  wexp;
        logic        lone_vld;
        apply_reset();
        bus.trd_en = 8'h01;
        for (int i = 0; i < 5; i++) begin
            bus.pc_wr      = (i == 0) ? 8'h01 : 8'h00;
            bus.nxt_pc_0   = (i == 0) ? 32'h0000_0777 : 32'h0000_0888;
            bus.i_miss     = (i == 0); bus.i_miss_trd = 3'd3;
`ifdef TRD_SCHED_BACK2BACK_EN
            lone_vld = 1'b1;
`else
            lone_vld = ((i % 2) == 0);
`endif
            exp_q.push_back({lone_vld, 3'd0, 32'h0000_0777});
            wait_q.push_back(8'h08);
            @(posedge clk);
            #1;
            got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
            exp = exp_q.pop_front();
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL lone[%0d]: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h", i,
                         got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
            end
            wexp = wait_q.pop_front();
            n_checks++;
            if (bus.trd_wait !== wexp) begin
                n_fail++;
                $display("FAIL lone_wait[%0d]: got %h want %h", i, bus.trd_wait, wexp);
            end
        end

        // Reset between edges: outputs must clear without a clock edge
        #2;
        rst = 1'b1;
        exp_q.push_back({1'b0, 3'd0, START_PC});
        wait_q.push_back(8'h00);
        #1;
        got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL async_rst: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h",
                     got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
        end
        wexp = wait_q.pop_front();
        n_checks++;
        if (bus.trd_wait !== wexp) begin
            n_fail++;
            $display("FAIL async_rst_wait: got %h want %h", bus.trd_wait, wexp);
        end

        // After release the PC file must be back at START_PC
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_idle();
        exp_q.push_back({1'b1, 3'd0, START_PC});
        @(posedge clk);
        #1;
        got = {bus.cur_vld, bus.cur_trd, bus.cur_pc};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL post_rst_issue: got vld/trd/pc=%b/%0d/%h want %b/%0d/%h",
                     got[35], got[34:32], got[31:0], exp[35], exp[34:32], exp[31:0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        set_idle();
        bus.trd_en = 8'h00;

        test_reset();
        test_round_robin();
        test_forwarding();
        test_d_miss();
        test_miss_fill_same_cycle();
        test_stall();
        test_lone_thread_async_reset();

        if (exp_q.size() != 0 || wait_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left, want 0/0",
                     exp_q.size(), wait_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trd_pc_sched.md
# trd_pc_sched

Per-thread PC register file and round-robin thread scheduler for the 8-thread barrel core. Consumes `nxt_pc_0..7`/`pc_wr` from the PC selector and holds the eight architectural PCs. Each cycle it picks the next runnable thread and drives the registered `cur_trd`/`cur_pc` back to fetch and the PC selector. Threads with an outstanding I-cache or D-cache miss are parked until their fill returns.

## Interface
Parameters:
- `START_PC`, default 32'h0000_0000: reset value of all eight PCs and of `cur_pc`.

Ports:
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `nxt_pc_0` .. `nxt_pc_7` in 32 each: next PC per thread.
- `pc_wr` in 8: bit t writes `nxt_pc_t` into PC[t].
- `stall` in 1: pipeline stall; freezes issue.
- `trd_en` in 8: thread enable mask.
- `i_miss` in 1, `i_miss_trd` in 3: I-miss reported for thread.
- `d_miss` in 1, `d_miss_trd` in 3: D-miss reported for thread.
- `i_fill` in 1, `i_fill_trd` in 3: I-miss fill complete for thread.
- `d_fill` in 1, `d_fill_trd` in 3: D-miss fill complete for thread.
- `cur_trd` out 3: issued thread (registered).
- `cur_pc` out 32: PC of issued thread (registered).
- `cur_vld` out 1: `cur_trd`/`cur_pc` valid.
- `trd_wait` out 8: bit t set while thread t is parked (iw[t] | dw[t]).

## Operation
- PC file: PC[t] <= `nxt_pc_t` when `pc_wr[t]`, regardless of `stall`.
- Wait flags: iw[t] and dw[t] are separate.
  - Set by a miss for thread t; cleared by a fill for thread t.
  - If a miss and a fill hit the same flag in the same cycle, set wins.
  - Flags update during `stall`.
- Next-state flags: iw_n/dw_n are the flag values after this cycle's miss/fill.
- Eligibility: elig[t] = `trd_en[t]` & ~iw_n[t] & ~dw_n[t].
- Round-robin pointer `ptr` (3 bits) holds the last issued thread; reset value 7.
- Issue, when `stall`=0: search t = ptr+1, ptr+2, ... mod 8 (wrap 7->0) for the first elig[t].
  - Found thread T: `cur_trd`<=T; `cur_pc`<= `pc_wr[T]` ? `nxt_pc_T` : PC[T] (same-edge write forwarding); `cur_vld`<=1; `ptr`<=T.
  - None found: `cur_vld`<=0; `cur_trd`, `cur_pc` and `ptr` hold.
- Stall: `cur_trd`, `cur_pc` and `ptr` hold.
  - If a miss targets `cur_trd` while `cur_vld`=1, `cur_vld`<=0.
  - Otherwise `cur_vld` holds.
- `trd_en[t]` deasserted: thread t is never selected. Its PC and flags still update.

## Timing
- Reset values: all PC[t]=`START_PC`, `cur_pc`=`START_PC`, `cur_trd`=0, `cur_vld`=0, iw=dw=0, `trd_wait`=0, `ptr`=7.
- Reset asserted mid-operation clears all state immediately (asynchronous), independent of clk.
- Issue latency: selection is registered. Inputs at edge N are reflected in `cur_*` after edge N.
- First edge after reset release with `trd_en`=8'h01 and `stall`=0: `cur_trd`=0, `cur_vld`=1.
- Miss at edge N on thread t: t is not issued at edge N or later until its fill.
- Fill at edge N: t is eligible at edge N itself.
- `trd_wait` is registered: it reflects flags after the edge.
- Write forwarding means a PC written at edge N is what issues at edge N. There is no stale read.

## Configuration
- `TRD_SCHED_BACK2BACK_EN` defined: the thread issued last (`cur_trd` with `cur_vld`=1) stays eligible. A lone runnable thread issues every cycle.
- Undefined: the last issued thread is excluded from the search at the next non-stalled edge (barrel interleave).
  - A lone runnable thread issues every other cycle: `cur_vld` alternates 1,0.
  - An excluded thread becomes eligible again after one non-issuing edge.

## Test plan
- Reset, `trd_en`=8'hFF, `stall`=0, no `pc_wr`: `cur_trd` sequence 0,1,...,7,0. `cur_pc`=`START_PC` each cycle. `cur_vld`=1 throughout.
- `trd_en`=8'h24, `pc_wr` writes `nxt_pc_2`=32'h10, `nxt_pc_5`=32'h20 at edge 1: issue order 2,5,2,5. The first issue of each thread shows 32'h10 / 32'h20 (forwarding).
- `trd_en`=8'h0F; `d_miss` on thread 1 at edge 3; `d_fill` on thread 1 at edge 9: thread 1 skipped (order 0,2,3) in that window. `trd_wait[1]`=1 after edge 3 and 0 after edge 9. Thread 1 issues again on its next turn.
- `i_miss` and `i_fill` on thread 4 in the same cycle: iw[4]=1 and thread 4 is skipped.
- `stall`=1 for 3 cycles with `pc_wr[cur_trd]` and a `d_miss` on `cur_trd`: `cur_trd`/`cur_pc` hold, `cur_vld` drops to 0, the PC is updated, and the next issue after the stall skips that thread.
- `trd_en`=8'h01 only: with the macro, `cur_vld`=1 every cycle; without it, `cur_vld` toggles 1,0,1,0. `rst` pulsed mid-sequence: all outputs return to reset values asynchronously.
